// File: rtl/dpll_backtrack_ctrl.sv
// dpll_backtrack_ctrl: DPLL search sequencer (decide -> BCP -> backtrack) owning the decider stack.
// Ports:
//   clock/reset          single clock, synchronous active-high reset (aborts any solve)
//   start                begins a solve from IDLE
//   dec_*                decision handshake (dec_none wins over dec_valid)
//   bcp_*                propagation launch pulse and done/conflict result
//   stk_*                decider stack push/pop; stk_idx_out valid while stk_pop=1
//   asg_*                assignment write / clear of asg_var
//   undo_pulse/level     trail unwind request to the level being backtracked to
//   depth                current decision level
//   busy/sat/unsat/err   status; sat/unsat/err hold until reset
module dpll_backtrack_ctrl #(
   parameter int MAX_VARS = 16,
   parameter int VAR_BITS = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic                dec_req,
   input  logic                dec_valid,
   input  logic                dec_none,
   input  logic [VAR_BITS-1:0] dec_var,
   input  logic                dec_pol,
   output logic                bcp_start,
   input  logic                bcp_done,
   input  logic                bcp_conflict,
   output logic                stk_push,
   output logic                stk_pop,
   output logic [VAR_BITS-1:0] stk_idx_in,
   input  logic [VAR_BITS-1:0] stk_idx_out,
   output logic                asg_we,
   output logic                asg_clr,
   output logic [VAR_BITS-1:0] asg_var,
   output logic                asg_val,
   output logic                undo_pulse,
   output logic [VAR_BITS:0]   undo_level,
   output logic [VAR_BITS:0]   depth,
   output logic                busy,
   output logic                sat,
   output logic                unsat,
   output logic                err
);
   localparam int NLVL = 1 << VAR_BITS;
   localparam logic [VAR_BITS:0] MAX_D = MAX_VARS[VAR_BITS:0];

   typedef enum logic [2:0] {S_IDLE, S_PROP, S_DECIDE, S_BT_POP, S_BT_CHK, S_SAT, S_UNSAT} state_t;

   state_t              state_q, state_d;
   logic [VAR_BITS:0]   depth_q, depth_d;
   logic [NLVL-1:0]     pol_q, pol_d, flip_q, flip_d;
   logic [VAR_BITS-1:0] bt_var_q, bt_var_d, lvl;
   logic                bcp_pend_q, bcp_pend_d, err_q, err_d, dec_ok;

   // Level slot addressed by the current depth; only used while depth < MAX_VARS.
   assign lvl    = depth_q[VAR_BITS-1:0];
   // A decision is accepted only if the decider offers one and a free level remains.
   assign dec_ok = dec_valid && !dec_none && depth_q != MAX_D;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         depth_q    <= '0;
         pol_q      <= '0;
         flip_q     <= '0;
         bt_var_q   <= '0;
         bcp_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         depth_q    <= depth_d;
         pol_q      <= pol_d;
         flip_q     <= flip_d;
         bt_var_q   <= bt_var_d;
         bcp_pend_q <= bcp_pend_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      pol_d    = pol_q;
      flip_d   = flip_q;
      bt_var_d = bt_var_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE:   state_d = start ? S_PROP : S_IDLE;
         S_PROP:   if (bcp_done) state_d = !bcp_conflict ? S_DECIDE : (depth_q == '0) ? S_UNSAT : S_BT_POP;
         S_DECIDE: begin
            if (dec_none) state_d = S_SAT;
            else if (dec_valid && !dec_ok) begin
               err_d   = 1'b1;
               state_d = S_UNSAT;
            end else if (dec_ok) begin
               pol_d[lvl]  = dec_pol;
               flip_d[lvl] = 1'b0;
               depth_d     = depth_q + 1'b1;
               state_d     = S_PROP;
            end
         end
         S_BT_POP: begin
            bt_var_d = stk_idx_out;
            depth_d  = depth_q - 1'b1;
            state_d  = S_BT_CHK;
         end
         S_BT_CHK: begin
            // Exhausted level: keep unwinding; untried level: take the opposite branch.
            if (flip_q[lvl]) state_d = (depth_q == '0) ? S_UNSAT : S_BT_POP;
            else begin
               flip_d[lvl] = 1'b1;
               depth_d     = depth_q + 1'b1;
               state_d     = S_PROP;
            end
         end
         default: state_d = state_q;
      endcase
      // bcp_start fires only on the first cycle of each PROP visit.
      bcp_pend_d = state_d == S_PROP && state_q != S_PROP;
   end

   always_comb begin
      dec_req    = state_q == S_DECIDE;
      bcp_start  = state_q == S_PROP && bcp_pend_q;
      stk_pop    = state_q == S_BT_POP;
      undo_pulse = state_q == S_BT_CHK;
      undo_level = undo_pulse ? depth_q : '0;
      stk_push   = 1'b0;
      stk_idx_in = '0;
      asg_we     = 1'b0;
      asg_clr    = 1'b0;
      asg_var    = '0;
      asg_val    = 1'b0;
      if (state_q == S_DECIDE && dec_ok) begin
         asg_we     = 1'b1;
         asg_var    = dec_var;
         asg_val    = dec_pol;
         stk_push   = 1'b1;
         stk_idx_in = dec_var;
      end
      if (state_q == S_BT_CHK) begin
         asg_var    = bt_var_q;
         asg_clr    = flip_q[lvl];
         asg_we     = !flip_q[lvl];
         asg_val    = !flip_q[lvl] && !pol_q[lvl];
         stk_push   = !flip_q[lvl];
         stk_idx_in = flip_q[lvl] ? '0 : bt_var_q;
      end
      busy  = state_q inside {S_PROP, S_DECIDE, S_BT_POP, S_BT_CHK};
      sat   = state_q == S_SAT;
      unsat = state_q == S_UNSAT;
      err   = err_q;
      depth = depth_q;
   end
endmodule
